// File: rtl/vigna_bus_arbiter.sv
// vigna_bus_arbiter: round-robin merge of the vigna I/D buses onto one memory port,
// with a per-transaction watchdog that aborts hung slave accesses.
module vigna_bus_arbiter #(
  parameter logic [15:0] TIMEOUT   = 16'd255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        timeout_err,
  output logic [7:0]  err_count
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state;
  logic        grant, last_grant, done, abort, pick;
  logic [15:0] cnt;
  always_comb begin
    done    = state == BUSY && m_ready;
    abort   = state == BUSY && !m_ready && TIMEOUT != 16'd0 && cnt == TIMEOUT - 16'd1;
    pick    = (i_valid && d_valid) ? !last_grant : d_valid;
    i_ready = (done || abort) && !grant;
    d_ready = (done || abort) && grant;
    i_rdata = abort ? ERR_RDATA : m_rdata;
    d_rdata = abort ? ERR_RDATA : m_rdata;
  end
  // valid inputs are only sampled in IDLE, so m_* never depend combinationally on them
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b0;
      cnt         <= 16'd0;
      m_valid     <= 1'b0;
      m_addr      <= 32'd0;
      m_wdata     <= 32'd0;
      m_wstrb     <= 4'd0;
      timeout_err <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (i_valid || d_valid) begin
          state      <= BUSY;
          grant      <= pick;
          last_grant <= pick;
          cnt        <= 16'd0;
          m_valid    <= 1'b1;
          m_addr     <= pick ? d_addr : i_addr;
          m_wdata    <= pick ? d_wdata : i_wdata;
          m_wstrb    <= pick ? d_wstrb : i_wstrb;
        end
      end else if (done || abort) begin
        state   <= IDLE;
        m_valid <= 1'b0;
        if (abort) begin
          timeout_err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// tb_vigna_bus_arbiter: directed vector table plus hand sequences for ties, watchdog,
// saturation, reset mid-transaction, and a second instance with the watchdog disabled.
module tb_vigna_bus_arbiter;
  logic        clk = 1'b0, resetn = 1'b0, z_resetn = 1'b0;
  logic        i_valid = 1'b0, d_valid = 1'b0, m_ready = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0, d_addr = '0, d_wdata = '0, m_rdata = 32'hBAD0BAD0;
  logic [3:0]  i_wstrb = '0, d_wstrb = '0;
  logic        i_ready, d_ready, m_valid, timeout_err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [7:0]  err_count;
  logic        z_dv = 1'b0, z_mr = 1'b0;
  logic [31:0] z_mrd = '0;
  logic        z_ir, z_dr, z_mv, z_terr;
  logic [31:0] z_irdata, z_drdata, z_maddr, z_mwdata;
  logic [3:0]  z_mwstrb;
  logic [7:0]  z_errc;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vigna_bus_arbiter #(.TIMEOUT(16'd4)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .timeout_err(timeout_err), .err_count(err_count)
  );

  vigna_bus_arbiter #(.TIMEOUT(16'd0)) dut0 (
    .clk(clk), .resetn(z_resetn),
    .i_valid(1'b0), .i_ready(z_ir), .i_addr(32'd0), .i_wdata(32'd0), .i_wstrb(4'd0), .i_rdata(z_irdata),
    .d_valid(z_dv), .d_ready(z_dr), .d_addr(32'h7000), .d_wdata(32'd0), .d_wstrb(4'd0), .d_rdata(z_drdata),
    .m_valid(z_mv), .m_ready(z_mr), .m_addr(z_maddr), .m_wdata(z_mwdata), .m_wstrb(z_mwstrb), .m_rdata(z_mrd),
    .timeout_err(z_terr), .err_count(z_errc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 1, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 2, 32'h0};
    tbl[2] = '{1'b1, 32'h0000_3000, 32'h0,         4'b0000, 0, 32'hCAFE_F00D};
    tbl[3] = '{1'b0, 32'h0000_0044, 32'hA5A5_5A5A, 4'b1111, 2, 32'h1111_1111};
    tbl[4] = '{1'b1, 32'h0000_3008, 32'h0,         4'b0000, 3, 32'h2222_2222};
    fork
      begin
        repeat (3) @(negedge clk);
        chk("reset m_valid", 32'(m_valid), 32'd0);
        chk("reset m_addr", m_addr, 32'd0);
        chk("reset m_wdata", m_wdata, 32'd0);
        chk("reset m_wstrb/terr/errc", {19'd0, m_wstrb, timeout_err, err_count}, 32'd0);
        chk("reset readies", 32'({i_ready, d_ready}), 32'd0);
        resetn = 1'b1;
        // first tie after reset goes to D, I stays pending
        @(negedge clk);
        i_valid = 1'b1; i_addr = 32'hA0; d_valid = 1'b1; d_addr = 32'hB0;
        @(negedge clk);
        chk("tie1 m_valid", 32'(m_valid), 32'd1);
        chk("tie1 m_addr", m_addr, 32'hB0);
        m_ready = 1'b1; m_rdata = 32'h0000_0001; #1;
        chk("tie1 readies", 32'({i_ready, d_ready}), 32'b01);
        @(negedge clk);
        m_ready = 1'b0; d_valid = 1'b0;
        chk("tie1 idle gap", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("tie1 I granted", m_addr, 32'hA0);
        m_ready = 1'b1; m_rdata = 32'h0000_0002; #1;
        chk("tie1 I readies", 32'({i_ready, d_ready}), 32'b10);
        chk("tie1 I rdata", i_rdata, 32'h2);
        @(negedge clk);
        m_ready = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; d_valid = 1'b1; d_addr = 32'hB4;
        @(negedge clk);
        chk("tie2 to D", m_addr, 32'hB4);
        m_ready = 1'b1; #1;
        chk("tie2 readies", 32'({i_ready, d_ready}), 32'b01);
        @(negedge clk);
        m_ready = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        chk("tie2 I pending", m_addr, 32'hA0);
        m_ready = 1'b1; #1;
        chk("tie2 I readies", 32'({i_ready, d_ready}), 32'b10);
        @(negedge clk);
        m_ready = 1'b0; i_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
          @(negedge clk);
          if (tbl[n].d) begin
            d_valid = 1'b1; d_addr = tbl[n].addr; d_wdata = tbl[n].wdata; d_wstrb = tbl[n].wstrb;
          end else begin
            i_valid = 1'b1; i_addr = tbl[n].addr; i_wdata = tbl[n].wdata; i_wstrb = tbl[n].wstrb;
          end
          @(negedge clk);
          chk("vec m_valid", 32'(m_valid), 32'd1);
          for (int k = 0; k < tbl[n].lat; k++) begin
            chk("vec ready early", 32'({i_ready, d_ready}), 32'd0);
            @(negedge clk);
          end
          chk("vec m_addr", m_addr, tbl[n].addr);
          chk("vec m_wdata", m_wdata, tbl[n].wdata);
          chk("vec m_wstrb", 32'(m_wstrb), 32'(tbl[n].wstrb));
          m_ready = 1'b1; m_rdata = tbl[n].rd; #1;
          chk("vec readies", 32'({i_ready, d_ready}), tbl[n].d ? 32'b01 : 32'b10);
          chk("vec rdata", tbl[n].d ? d_rdata : i_rdata, tbl[n].rd);
          @(negedge clk);
          m_ready = 1'b0; m_rdata = 32'hBAD0BAD0; i_valid = 1'b0; d_valid = 1'b0;
          chk("vec idle", 32'(m_valid), 32'd0);
          chk("vec no error", 32'({timeout_err, err_count}), 32'd0);
        end
        // watchdog abort in the 4th BUSY cycle
        @(negedge clk);
        d_valid = 1'b1; d_addr = 32'h500; d_wstrb = 4'd0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          chk("wd ready early", 32'(d_ready), 32'd0);
          @(negedge clk);
        end
        chk("wd d_ready", 32'(d_ready), 32'd1);
        chk("wd d_rdata", d_rdata, 32'h13);
        chk("wd i_rdata", i_rdata, 32'h13);
        chk("wd terr early", 32'(timeout_err), 32'd0);
        @(negedge clk);
        d_valid = 1'b0;
        chk("wd terr pulse", 32'(timeout_err), 32'd1);
        chk("wd err_count", 32'(err_count), 32'd1);
        chk("wd m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("wd terr one cycle", 32'(timeout_err), 32'd0);
        begin
          int sat_ok;
          logic ok;
          sat_ok = 0;
          for (int n = 0; n < 300; n++) begin
            d_valid = 1'b1; d_addr = 32'h600;
            ok = 1'b0;
            for (int k = 0; k < 10 && !ok; k++) begin
              @(negedge clk);
              ok = d_ready;
            end
            if (ok) sat_ok++;
            @(negedge clk);
            d_valid = 1'b0;
            @(negedge clk);
          end
          chk("sat aborts seen", 32'(sat_ok), 32'd300);
          chk("sat err_count", 32'(err_count), 32'd255);
        end
        // asynchronous reset while BUSY
        @(negedge clk);
        d_valid = 1'b1; d_addr = 32'h800;
        @(negedge clk);
        chk("rst busy m_valid", 32'(m_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst async m_valid", 32'(m_valid), 32'd0);
        chk("rst readies", 32'({i_ready, d_ready}), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        d_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        i_valid = 1'b1; i_addr = 32'h900; i_wstrb = 4'd0;
        @(negedge clk);
        chk("post rst m_valid", 32'(m_valid), 32'd1);
        chk("post rst m_addr", m_addr, 32'h900);
        m_ready = 1'b1; m_rdata = 32'h3333_3333; #1;
        chk("post rst i_ready", 32'({i_ready, d_ready}), 32'b10);
        @(negedge clk);
        m_ready = 1'b0; i_valid = 1'b0;
      end
      begin
        logic bad;
        repeat (3) @(negedge clk);
        z_resetn = 1'b1;
        @(negedge clk);
        z_dv = 1'b1;
        bad = 1'b0;
        repeat (70000) begin
          @(negedge clk);
          if (z_dr || z_terr || !z_mv) bad = 1'b1;
        end
        chk("nowd never aborted", 32'(bad), 32'd0);
        chk("nowd err_count", 32'(z_errc), 32'd0);
        chk("nowd m_addr", z_maddr, 32'h7000);
        z_mr = 1'b1; z_mrd = 32'h0000_0055; #1;
        chk("nowd d_ready", 32'(z_dr), 32'd1);
        chk("nowd d_rdata", z_drdata, 32'h55);
        @(negedge clk);
        z_mr = 1'b0; z_dv = 1'b0;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
